// File: rtl/hx711_reader_if.sv
// Signal bundle between the HX711 sequencer, the HX711 pins and the sample consumer.
interface hx711_reader_if;
    logic        en;
    logic [1:0]  gain_sel;
    logic        pwr_dn;
    logic        dout;
    logic        pd_sck;
    logic [23:0] data;
    logic        data_valid;
    logic        busy;

    modport master (
        output en, gain_sel, pwr_dn, dout,
        input  pd_sck, data, data_valid, busy
    );

    modport slave (
        input  en, gain_sel, pwr_dn, dout,
        output pd_sck, data, data_valid, busy
    );
endinterface

// File: rtl/hx711_reader.sv
// HX711 load-cell ADC sequencer: waits for DOUT low, clocks out a 24-bit sample plus
// 1-3 gain-select pulses on PD_SCK, and handles power-down.
module hx711_reader #(
    parameter int CLK_DIV = 50,
    parameter int CW      = 16
) (
    input  logic           clk,
    input  logic           rst,
    hx711_reader_if.slave  bus
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_RDY = 3'd1;
    localparam logic [2:0] S_HIGH     = 3'd2;
    localparam logic [2:0] S_LOW      = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;
    localparam logic [2:0] S_PDOWN    = 3'd5;

    localparam logic [CW-1:0] TICK_LAST = CW'(CLK_DIV - 1);
    localparam logic [4:0]    DATA_BITS = 5'd24;

    logic [2:0]    state;
    logic [CW-1:0] tick;
    logic [4:0]    bit_idx;
    logic [4:0]    pulses;
    logic [4:0]    bit_next;
    logic [23:0]   shift;
    logic          dout_meta;
    logic          dout_s;
    logic          phase_end;

    // Pulse count selects the next conversion's channel and gain on the HX711.
    function automatic logic [4:0] pulse_count(input logic [1:0] g);
        case (g)
            2'b10:   return 5'd26;
            2'b11:   return 5'd27;
            default: return 5'd25;
        endcase
    endfunction

    // NOTE: the synchronizer resets to 1 (DOUT idle/not-ready level) so that
    // leaving reset can never look like a data-ready edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_meta <= 1'b1;
            dout_s    <= 1'b1;
        end else begin
            dout_meta <= bus.dout;
            dout_s    <= dout_meta;
        end
    end

    assign phase_end = (tick == TICK_LAST);
    assign bit_next  = bit_idx + 5'd1;

    // NOTE: all state, including pd_sck and the outputs, uses non-blocking
    // assignments so every register samples the pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            tick           <= '0;
            bit_idx        <= '0;
            pulses         <= '0;
            shift          <= '0;
            bus.pd_sck     <= 1'b0;
            bus.data       <= '0;
            bus.data_valid <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            bus.data_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.pwr_dn) begin
                        state      <= S_PDOWN;
                        bus.pd_sck <= 1'b1;
                    end else if (bus.en) begin
                        state <= S_WAIT_RDY;
                    end
                end

                S_WAIT_RDY: begin
                    if (bus.pwr_dn) begin
                        state      <= S_PDOWN;
                        bus.pd_sck <= 1'b1;
                    end else if (!bus.en) begin
                        state <= S_IDLE;
                    end else if (!dout_s) begin
                        pulses     <= pulse_count(bus.gain_sel);
                        tick       <= '0;
                        bit_idx    <= '0;
                        state      <= S_HIGH;
                        bus.pd_sck <= 1'b1;
                        bus.busy   <= 1'b1;
                    end
                end

                S_HIGH: begin
                    if (phase_end) begin
                        // Gain-select pulses beyond the 24 data bits carry no data.
                        if (bit_idx < DATA_BITS) begin
                            shift <= {shift[22:0], dout_s};
                        end
                        tick       <= '0;
                        state      <= S_LOW;
                        bus.pd_sck <= 1'b0;
                    end else begin
                        tick <= tick + CW'(1);
                    end
                end

                S_LOW: begin
                    if (phase_end) begin
                        tick    <= '0;
                        bit_idx <= bit_next;
                        if (bit_next == pulses) begin
                            state          <= S_DONE;
                            bus.busy       <= 1'b0;
                            bus.data       <= shift;
                            bus.data_valid <= 1'b1;
                        end else begin
                            state      <= S_HIGH;
                            bus.pd_sck <= 1'b1;
                        end
                    end else begin
                        tick <= tick + CW'(1);
                    end
                end

                S_DONE: begin
                    // en/pwr_dn requests raised mid-frame are honoured here.
                    if (bus.pwr_dn) begin
                        state      <= S_PDOWN;
                        bus.pd_sck <= 1'b1;
                    end else if (bus.en) begin
                        state <= S_WAIT_RDY;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                S_PDOWN: begin
                    if (!bus.pwr_dn) begin
                        state      <= S_IDLE;
                        bus.pd_sck <= 1'b0;
                    end
                end

                default: begin
                    state      <= S_IDLE;
                    tick       <= '0;
                    bus.pd_sck <= 1'b0;
                    bus.busy   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hx711_reader.sv
// Bench for hx711_reader: behavioural HX711 device model, PD_SCK/busy monitor,
// table-driven and randomized frames, plus power-down, reset and gain-change sequences.
module tb_hx711_reader;
    localparam int CLK_DIV = 4;
    localparam int CW      = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hx711_reader_if bus ();

    hx711_reader #(.CLK_DIV(CLK_DIV), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]  gain;
        logic [23:0] sample;
        int          pulses;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // HX711 device model: DOUT low when a conversion is ready, next bit (MSB first)
    // presented on each PD_SCK rise, DOUT high from the 25th rise on.
    logic [23:0] arm_value = '0;
    logic        arm_tgl   = 1'b0;

    initial begin : hx_model
        logic        seen;
        int          cnt;
        logic [23:0] smp;
        seen = 1'b0;
        cnt  = 0;
        smp  = '0;
        bus.dout = 1'b1;
        forever begin
            @(posedge bus.pd_sck or arm_tgl);
            if (arm_tgl != seen) begin
                seen = arm_tgl;
                smp  = arm_value;
                cnt  = 0;
                bus.dout = 1'b0;
            end else if (bus.pd_sck) begin
                cnt++;
                bus.dout = (cnt <= 24) ? smp[24-cnt] : 1'b1;
            end
        end
    end

    // Monitor: cumulative counts sampled on the falling clock edge.
    int rise_cnt   = 0;
    int valid_cnt  = 0;
    int busy_cyc   = 0;
    int width_err  = 0;
    int timing_err = 0;

    initial begin : monitor
        int   hi_run;
        int   lo_run;
        logic prev_sck;
        logic prev_busy;
        hi_run = 0; lo_run = 0; prev_sck = 1'b0; prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                hi_run = 0; lo_run = 0; prev_sck = 1'b0; prev_busy = 1'b0;
            end else begin
                if (bus.pd_sck && !prev_sck) begin
                    rise_cnt++;
                    if (prev_busy && lo_run != CLK_DIV) width_err++;
                    hi_run = 1;
                end else if (!bus.pd_sck && prev_sck) begin
                    if (prev_busy && hi_run != CLK_DIV) width_err++;
                    lo_run = 1;
                end else if (bus.pd_sck) begin
                    hi_run++;
                end else begin
                    lo_run++;
                end
                if (bus.data_valid) begin
                    valid_cnt++;
                    if (bus.busy || !prev_busy) timing_err++;
                end
                if (bus.busy) busy_cyc++;
                prev_sck  = bus.pd_sck;
                prev_busy = bus.busy;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference rule: 00/01 -> 25 pulses, 10 -> 26, 11 -> 27.
    function automatic int exp_pulses(input logic [1:0] g);
        return 25 + ((g == 2'b10) ? 1 : 0) + ((g == 2'b11) ? 2 : 0);
    endfunction

    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic arm(input logic [23:0] v);
        arm_value = v;
        arm_tgl   = ~arm_tgl;
    endtask

    int r0, v0, b0, w0, t0;

    task automatic snap();
        r0 = rise_cnt; v0 = valid_cnt; b0 = busy_cyc; w0 = width_err; t0 = timing_err;
    endtask

    task automatic wait_rise(input int n, input string name);
        int k = 0;
        while (rise_cnt < n && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check({name, "_reached"}, 32'(rise_cnt >= n), 32'd1);
    endtask

    // Arms the device model right after a clock edge and measures the PD_SCK latency.
    task automatic start_frame(input logic [1:0] g, input logic [23:0] smp, input int gap,
                               input string name);
        int lat = 0;
        bus.gain_sel = g;
        clocks(gap);
        @(posedge clk);
        #1;
        snap();
        arm(smp);
        while (!bus.pd_sck && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'd3);
    endtask

    task automatic finish_frame(input int exp_p, input logic [23:0] exp_d, input string name);
        int k = 0;
        while (!bus.data_valid && k < 600) begin
            @(negedge clk);
            k++;
        end
        check({name, "_valid_seen"}, 32'(bus.data_valid), 32'd1);
        check({name, "_data"}, {8'h0, bus.data}, {8'h0, exp_d});
        check({name, "_pulses"}, 32'(rise_cnt - r0), 32'(exp_p));
        clocks(3);
        check({name, "_valid_once"}, 32'(valid_cnt - v0), 32'd1);
        check({name, "_busy_len"}, 32'(busy_cyc - b0), 32'(2 * CLK_DIV * exp_p));
        check({name, "_widths"}, 32'(width_err - w0), 32'd0);
        check({name, "_valid_timing"}, 32'(timing_err - t0), 32'd0);
    endtask

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t        vecs[6];
        logic [1:0]  g;
        logic [23:0] s;

        vecs[0] = '{gain: 2'b00, sample: 24'hA5F00F, pulses: 25};
        vecs[1] = '{gain: 2'b10, sample: 24'h800001, pulses: 26};
        vecs[2] = '{gain: 2'b11, sample: 24'h7FFFFF, pulses: 27};
        vecs[3] = '{gain: 2'b01, sample: 24'h000000, pulses: 25};
        vecs[4] = '{gain: 2'b10, sample: 24'hFFFFFF, pulses: 26};
        vecs[5] = '{gain: 2'b00, sample: 24'h5A5A5A, pulses: 25};

        bus.en = 1'b0;
        bus.gain_sel = 2'b00;
        bus.pwr_dn = 1'b0;

        // Reset state
        #23;
        check("rst_pd_sck", 32'(bus.pd_sck), 32'd0);
        check("rst_data", {8'h0, bus.data}, 32'd0);
        check("rst_valid", 32'(bus.data_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        bus.en = 1'b1;

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            start_frame(vecs[i].gain, vecs[i].sample, 2, nm);
            finish_frame(vecs[i].pulses, vecs[i].sample, nm);
        end

        // DOUT held high: nothing may start
        snap();
        clocks(1000);
        #1;
        check("idle_rises", 32'(rise_cnt - r0), 32'd0);
        check("idle_valid", 32'(valid_cnt - v0), 32'd0);
        check("idle_busy_cyc", 32'(busy_cyc - b0), 32'd0);
        check("idle_pd_sck", 32'(bus.pd_sck), 32'd0);

        // Randomized frames against the reference rules
        for (int i = 0; i < 8; i++) begin
            string nm;
            nm = $sformatf("rnd%0d", i);
            g  = 2'($urandom_range(0, 3));
            s  = 24'($urandom());
            start_frame(g, s, 2 + $urandom_range(0, 20), nm);
            finish_frame(exp_pulses(g), s, nm);
        end

        // Power-down and en drop at pulse 10: frame completes, then PDOWN
        start_frame(2'b00, 24'h3C3C3C, 2, "pdn");
        wait_rise(r0 + 10, "pdn_p10");
        bus.pwr_dn = 1'b1;
        bus.en = 1'b0;
        finish_frame(25, 24'h3C3C3C, "pdn");
        check("pdn_sck_high", 32'(bus.pd_sck), 32'd1);
        clocks(50);
        #1;
        check("pdn_sck_hold", 32'(bus.pd_sck), 32'd1);
        bus.pwr_dn = 1'b0;
        @(posedge clk);
        #1;
        check("pdn_exit_sck", 32'(bus.pd_sck), 32'd0);
        check("pdn_exit_busy", 32'(bus.busy), 32'd0);

        // Reset at pulse 12: immediate pd_sck/data clear, then a clean new frame
        bus.en = 1'b1;
        start_frame(2'b00, 24'h123456, 2, "rstm");
        wait_rise(r0 + 12, "rstm_p12");
        #2;
        rst = 1'b0;
        #1;
        check("rstm_pd_sck", 32'(bus.pd_sck), 32'd0);
        check("rstm_data", {8'h0, bus.data}, 32'd0);
        check("rstm_busy", 32'(bus.busy), 32'd0);
        arm(24'h0F1E2D);
        clocks(2);
        @(negedge clk);
        snap();
        rst = 1'b1;
        finish_frame(25, 24'h0F1E2D, "rstm_new");

        // gain_sel change mid-frame only affects the following frame
        start_frame(2'b00, 24'hC0FFEE, 2, "gmid_a");
        wait_rise(r0 + 5, "gmid_p5");
        bus.gain_sel = 2'b11;
        finish_frame(25, 24'hC0FFEE, "gmid_a");
        start_frame(2'b11, 24'h13579B, 2, "gmid_b");
        finish_frame(27, 24'h13579B, "gmid_b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hx711_reader.md
# hx711_reader

Sequencer for the HX711 24-bit load-cell ADC. It generates PD_SCK from an internal divide-by-CLK_DIV tick counter and waits for the converter's data-ready (DOUT low). It shifts in one 24-bit two's-complement sample per conversion, appends 1–3 gain-select pulses, and presents each sample with a one-cycle valid strobe. It sits between the HX711 pins and the user-side sample consumer, and also owns HX711 power-down sequencing.

## Interface
- CLK_DIV, 50 — system clocks per PD_SCK half-period; legal range 4..65535 (50 gives 1 µs at 50 MHz).
- CW, 16 — tick counter width; must satisfy 2^CW ≥ CLK_DIV.

- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- en  in  1  level; while high, conversions are read back to back.
- gain_sel  in  2  00/01 → 25 pulses (ch A, ×128); 10 → 26 (ch B, ×32); 11 → 27 (ch A, ×64).
- pwr_dn  in  1  level; requests HX711 power-down.
- dout  in  1  HX711 DOUT pin; asynchronous.
- pd_sck  out  1  HX711 PD_SCK pin; registered.
- data  out  24  last captured sample, MSB = first bit shifted.
- data_valid  out  1  one-cycle pulse when data updates.
- busy  out  1  high from first PD_SCK rise to the end of the last pulse's low phase.

## Operation
- dout passes through a 2-flop synchronizer (dout_s); all decisions use dout_s.
- States:
  - IDLE: pd_sck=0. If pwr_dn=1 → PDOWN; else if en=1 → WAIT_RDY.
  - WAIT_RDY: pd_sck=0.
    - pwr_dn=1 → PDOWN; else en=0 → IDLE.
    - Else on dout_s=0: latch pulse count from gain_sel (25/26/27), clear the tick counter and bit index → HIGH.
  - HIGH: pd_sck=1 for CLK_DIV clocks. On the last clock of the phase, if bit index < 24, shift dout_s into the 24-bit shift register (LSB in, shifting left); otherwise ignore dout. → LOW.
  - LOW: pd_sck=0 for CLK_DIV clocks. On the last clock, increment the bit index. If the index equals the latched pulse count → DONE; else → HIGH.
  - DONE (1 cycle): data ← shift register; data_valid=1. If pwr_dn=1 → PDOWN; else if en=1 → WAIT_RDY; else → IDLE.
  - PDOWN: pd_sck=1 continuously. When pwr_dn=0, drive pd_sck=0 → IDLE.
- The tick counter is a mod-CLK_DIV counter. It is cleared on every state entry, so every phase is exactly CLK_DIV clocks.
- en=0 or pwr_dn=1 during HIGH/LOW does not abort the frame. The frame completes and the request is honored from DONE.
- gain_sel changes mid-frame take effect at the next frame only.
- After PDOWN exit, the HX711 reverts to ×128. The first sample after wake is at ×128 regardless of gain_sel. This is documented behavior; the block takes no action.
- No sign extension; data is the raw 24-bit two's-complement value.

## Timing
- Reset values: pd_sck=0, data=0, data_valid=0, busy=0, state=IDLE, counters=0.
- Reset mid-frame forces pd_sck=0 on assertion. A partial frame is discarded.
  - If the PD_SCK high time is under 60 µs, the HX711 completes nothing.
  - The next frame restarts from WAIT_RDY after dout_s goes low.
- dout pin falling while in WAIT_RDY: pd_sck rises 3 clocks later (2 sync + 1 state).
- Frame length is 2·CLK_DIV·P clocks for P pulses. data_valid pulses on the clock after the last LOW phase ends, and busy falls on the same clock.
- Sampling instant: the last clock of each HIGH phase, i.e. CLK_DIV−1 clocks after the rise. This satisfies HX711 t2 ≤ 0.1 µs when CLK_DIV·Tclk ≥ 0.2 µs.
- Back-to-back frames: after DONE, WAIT_RDY sees dout_s high (the HX711 holds DOUT high until the next conversion), so no spurious frame starts.

## Test plan
- CLK_DIV=4, gain_sel=00, model returns 0xA5F00F → exactly 25 pd_sck pulses, each 4 clk high and 4 clk low; data=0xA5F00F; one data_valid pulse; busy high for 200 clk.
- gain_sel=10, sample 0x800001 → 26 pulses, data=0x800001. Then gain_sel=11 with sample 0x7FFFFF → 27 pulses, data=0x7FFFFF.
- en=1, dout held high for 1000 clk → pd_sck stays 0, data_valid never asserts, busy=0.
- Assert pwr_dn and drop en at pulse 10 → frame completes with 25 pulses and data_valid. Then pd_sck stays 1 while pwr_dn=1, and falls 1 clk after pwr_dn=0.
- rst low at pulse 12 → pd_sck=0 and data=0 immediately. After release, with dout low, a full new 25-pulse frame captures the new sample.
- Change gain_sel 00→11 mid-frame → current frame uses 25 pulses, next frame uses 27.
